// File: rtl/monopulse_scheduler_if.sv
// -----------------------------------------------------------------------------
// monopulse_scheduler_if
//
// Groups every signal between the monopulse scheduler and its neighbours:
// the enable control, the memory reader (sample inputs and advance pulse),
// the divider (operands, start, result, valid) and the per-sample result
// outputs. Only the clock and reset are left as plain module ports.
//
// Modports:
//   master : scheduler view (drives o_*, samples i_*)
//   slave  : environment view (drives i_*, samples o_*)
// -----------------------------------------------------------------------------
interface monopulse_scheduler_if #(
    parameter int DATA_SIZE = 64,
    parameter int IDX_W     = 8
);
    // Control and reader side
    logic                   i_enable;
    logic [DATA_SIZE-1:0]   i_reference;
    logic [DATA_SIZE-1:0]   i_error;
    logic                   o_next;

    // Divider side
    logic                   o_div_start;
    logic [DATA_SIZE-1:0]   o_div_reference;
    logic [DATA_SIZE-1:0]   o_div_error;
    logic [2*DATA_SIZE-1:0] i_div_result;
    logic                   i_div_valid;

    // Per-sample result side
    logic [2*DATA_SIZE-1:0] o_result;
    logic                   o_result_valid;
    logic [IDX_W-1:0]       o_sample_idx;
    logic                   o_zero_ref;
    logic                   o_timeout;
    logic                   o_frame_done;
    logic [7:0]             o_timeout_count;
    logic                   o_busy;

    modport master (
        input  i_enable, i_reference, i_error, i_div_result, i_div_valid,
        output o_next, o_div_start, o_div_reference, o_div_error,
               o_result, o_result_valid, o_sample_idx, o_zero_ref,
               o_timeout, o_frame_done, o_timeout_count, o_busy
    );

    modport slave (
        output i_enable, i_reference, i_error, i_div_result, i_div_valid,
        input  o_next, o_div_start, o_div_reference, o_div_error,
               o_result, o_result_valid, o_sample_idx, o_zero_ref,
               o_timeout, o_frame_done, o_timeout_count, o_busy
    );
endinterface

// File: rtl/monopulse_scheduler.sv
// -----------------------------------------------------------------------------
// monopulse_scheduler
//
// Frame-level sequencer for the monopulse divider path. For each sample of a
// frame it latches the reference/error pair from the memory reader, starts
// one divide, waits for the quotient (or gives up after TIMEOUT cycles), and
// presents the result with its in-frame index and qualifying flags. A zero
// reference skips the divider and reports an all-ones quotient.
//
// Ports:
//   i_clock : single clock domain
//   i_reset : synchronous, active-high reset
//   bus     : monopulse_scheduler_if.master (reader, divider and result signals)
//
// Parameters:
//   DATA_SIZE : sample width (result is 2*DATA_SIZE)
//   FRAME_LEN : samples per frame (>= 2)
//   TIMEOUT   : WAIT cycles before a divide is abandoned (>= 1)
//   IDX_W     : sample index width (2**IDX_W >= FRAME_LEN)
// -----------------------------------------------------------------------------
module monopulse_scheduler #(
    parameter int DATA_SIZE = 64,
    parameter int FRAME_LEN = 16,
    parameter int TIMEOUT   = 255,
    parameter int IDX_W     = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    monopulse_scheduler_if.master bus
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX      = IDX_W'(FRAME_LEN - 1);
    localparam logic [TIMER_W-1:0] TIMER_EXPIRES = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_NEXT,
        ST_SETTLE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [DATA_SIZE-1:0]   div_reference_q, div_reference_d;
    logic [DATA_SIZE-1:0]   div_error_q, div_error_d;
    logic [2*DATA_SIZE-1:0] result_q, result_d;
    logic                   zero_ref_q, zero_ref_d;
    logic                   timeout_q, timeout_d;
    logic [7:0]             timeout_count_q, timeout_count_d;

    // State and datapath registers; reset clears everything so all outputs
    // read zero in IDLE immediately after reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            timer_q         <= '0;
            div_reference_q <= '0;
            div_error_q     <= '0;
            result_q        <= '0;
            zero_ref_q      <= 1'b0;
            timeout_q       <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            timer_q         <= timer_d;
            div_reference_q <= div_reference_d;
            div_error_q     <= div_error_d;
            result_q        <= result_d;
            zero_ref_q      <= zero_ref_d;
            timeout_q       <= timeout_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    // Next-state and datapath updates. Every register holds by default, so
    // operands and result stay stable between result pulses.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        timer_d         = timer_q;
        div_reference_d = div_reference_q;
        div_error_d     = div_error_q;
        result_d        = result_q;
        zero_ref_d      = zero_ref_q;
        timeout_d       = timeout_q;
        timeout_count_d = timeout_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_enable) begin
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                div_reference_d = bus.i_reference;
                div_error_d     = bus.i_error;
                timeout_d       = 1'b0;
                zero_ref_d      = (bus.i_reference == '0);
                // A zero reference would make the quotient meaningless, so the
                // divider is bypassed and a saturated quotient is reported.
                if (bus.i_reference == '0) begin
                    result_d = '1;
                    state_d  = ST_NEXT;
                end else begin
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // Valid is checked first so a result arriving on the final
                // timer cycle is still accepted.
                if (bus.i_div_valid) begin
                    result_d = bus.i_div_result;
                    state_d  = ST_NEXT;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_q == TIMER_EXPIRES) begin
                        result_d  = '0;
                        timeout_d = 1'b1;
                        if (timeout_count_q != 8'hFF) begin
                            timeout_count_d = timeout_count_q + 8'd1;
                        end
                        state_d = ST_NEXT;
                    end
                end
            end

            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
                state_d = ST_SETTLE;
            end

            ST_SETTLE: begin
                // idx wraps to zero only after the last sample, so zero here
                // marks a frame boundary where enable is re-evaluated.
                if (idx_q != '0 || bus.i_enable) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pulses are decoded from the state so each lasts exactly one cycle.
    assign bus.o_div_start     = (state_q == ST_START);
    assign bus.o_next          = (state_q == ST_NEXT);
    assign bus.o_result_valid  = (state_q == ST_NEXT);
    assign bus.o_frame_done    = (state_q == ST_NEXT) && (idx_q == LAST_IDX);
    assign bus.o_busy          = (state_q != ST_IDLE);

    assign bus.o_div_reference = div_reference_q;
    assign bus.o_div_error     = div_error_q;
    assign bus.o_result        = result_q;
    assign bus.o_sample_idx    = idx_q;
    assign bus.o_zero_ref      = zero_ref_q;
    assign bus.o_timeout       = timeout_q;
    assign bus.o_timeout_count = timeout_count_q;

endmodule

// File: tb/tb_monopulse_scheduler.sv
// -----------------------------------------------------------------------------
// tb_monopulse_scheduler
//
// Drives monopulse_scheduler with a memory reader model and a divider model
// whose response latency is chosen per sample. Sample records with expected
// outputs come from a table; expected results are queued when a frame is
// loaded and compared when the DUT pulses o_result_valid.
// -----------------------------------------------------------------------------
module tb_monopulse_scheduler;

    localparam int DATA_SIZE = 16;
    localparam int FRAME_LEN = 4;
    localparam int TIMEOUT   = 8;
    localparam int IDX_W     = 8;
    localparam int MEM_DEPTH = 64;

    logic i_clock;
    logic i_reset;

    monopulse_scheduler_if #(.DATA_SIZE(DATA_SIZE), .IDX_W(IDX_W)) sched_if ();

    monopulse_scheduler #(
        .DATA_SIZE(DATA_SIZE),
        .FRAME_LEN(FRAME_LEN),
        .TIMEOUT  (TIMEOUT),
        .IDX_W    (IDX_W)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .bus    (sched_if)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Memory reader model: registered sample pointer advanced by o_next.
    logic [DATA_SIZE-1:0] mem_ref [MEM_DEPTH];
    logic [DATA_SIZE-1:0] mem_err [MEM_DEPTH];
    int                   mem_lat [MEM_DEPTH];
    int                   rd_ptr = 0;

    always @(posedge i_clock) begin
        if (sched_if.o_next) rd_ptr <= rd_ptr + 1;
    end

    assign sched_if.i_reference = mem_ref[rd_ptr];
    assign sched_if.i_error     = mem_err[rd_ptr];

    // Divider model: valid for one cycle L cycles after the start cycle,
    // L taken from the sample table (0 means it never answers). It ignores
    // the scheduler reset, as a real divider would still finish.
    function automatic logic [2*DATA_SIZE-1:0] div_model(input logic [DATA_SIZE-1:0] r,
                                                         input logic [DATA_SIZE-1:0] e);
        logic [2*DATA_SIZE-1:0] num;
        logic [2*DATA_SIZE-1:0] den;
        num = {e, {DATA_SIZE{1'b0}}};
        den = {{DATA_SIZE{1'b0}}, r};
        return (den == '0) ? '1 : num / den;
    endfunction

    logic                   div_pend = 1'b0;
    int                     div_cnt = 0;
    logic [2*DATA_SIZE-1:0] div_quot = '0;
    int                     start_count = 0;

    initial begin
        sched_if.i_div_valid  = 1'b0;
        sched_if.i_div_result = '0;
    end

    always @(posedge i_clock) begin
        sched_if.i_div_valid <= 1'b0;
        if (sched_if.o_div_start) begin
            start_count <= start_count + 1;
            div_quot    <= div_model(sched_if.o_div_reference, sched_if.o_div_error);
            if (mem_lat[rd_ptr] == 1) begin
                sched_if.i_div_valid  <= 1'b1;
                sched_if.i_div_result <= div_model(sched_if.o_div_reference, sched_if.o_div_error);
                div_pend <= 1'b0;
            end else if (mem_lat[rd_ptr] >= 2) begin
                div_pend <= 1'b1;
                div_cnt  <= mem_lat[rd_ptr] - 2;
            end else begin
                div_pend <= 1'b0;
            end
        end else if (div_pend) begin
            if (div_cnt == 0) begin
                sched_if.i_div_valid  <= 1'b1;
                sched_if.i_div_result <= div_quot;
                div_pend <= 1'b0;
            end else begin
                div_cnt <= div_cnt - 1;
            end
        end
    end

    // Stimulus table and scoreboard
    typedef struct {
        logic [DATA_SIZE-1:0]   ref_v;
        logic [DATA_SIZE-1:0]   err_v;
        int                     lat;
        logic [2*DATA_SIZE-1:0] exp_result;
        logic                   exp_zero;
        logic                   exp_to;
        int                     gap;
    } vec_t;

    typedef struct {
        logic [2*DATA_SIZE-1:0] result;
        logic [DATA_SIZE-1:0]   ref_v;
        logic [DATA_SIZE-1:0]   err_v;
        int                     idx;
        logic                   zero;
        logic                   to;
        logic                   done;
        int                     gap;
    } exp_t;

    vec_t vecs [20];
    exp_t sb [$];
    int   wr_ptr = 0;
    int   check_count = 0;
    int   pass_count = 0;
    int   cycle_cnt = 0;
    int   last_valid_cyc = 0;
    int   valid_seen = 0;
    int   popped = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, actual, expected, cycle_cnt);
        end
    endtask

    // One cycle step: advance to the falling edge and compare any result.
    task automatic step();
        exp_t e;
        @(negedge i_clock);
        cycle_cnt++;
        if (sched_if.o_result_valid) begin
            valid_seen++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_result_valid", 64'(sched_if.o_result_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                popped++;
                checkOutput("result",     64'(sched_if.o_result),        64'(e.result));
                checkOutput("sample_idx", 64'(sched_if.o_sample_idx),    64'(e.idx));
                checkOutput("zero_ref",   64'(sched_if.o_zero_ref),      64'(e.zero));
                checkOutput("timeout",    64'(sched_if.o_timeout),       64'(e.to));
                checkOutput("frame_done", 64'(sched_if.o_frame_done),    64'(e.done));
                checkOutput("next_pulse", 64'(sched_if.o_next),          64'd1);
                checkOutput("div_ref",    64'(sched_if.o_div_reference), 64'(e.ref_v));
                checkOutput("div_err",    64'(sched_if.o_div_error),     64'(e.err_v));
                if (e.gap != 0) begin
                    checkOutput("sample_period", 64'(cycle_cnt - last_valid_cyc), 64'(e.gap));
                end
            end
            last_valid_cyc = cycle_cnt;
        end
        if (sched_if.o_frame_done && !sched_if.o_result_valid) begin
            checkOutput("frame_done_without_valid", 64'(sched_if.o_frame_done), 64'd0);
        end
    endtask

    // Loads table rows into the reader and queues their expected results.
    task automatic applyStimulus(input int first, input int count);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            mem_ref[wr_ptr] = vecs[first + i].ref_v;
            mem_err[wr_ptr] = vecs[first + i].err_v;
            mem_lat[wr_ptr] = vecs[first + i].lat;
            wr_ptr++;
            e.result = vecs[first + i].exp_result;
            e.ref_v  = vecs[first + i].ref_v;
            e.err_v  = vecs[first + i].err_v;
            e.idx    = i % FRAME_LEN;
            e.zero   = vecs[first + i].exp_zero;
            e.to     = vecs[first + i].exp_to;
            e.done   = ((i % FRAME_LEN) == FRAME_LEN - 1);
            e.gap    = vecs[first + i].gap;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_enable();
        sched_if.i_enable = 1'b1;
        step();
        sched_if.i_enable = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        checkOutput({name, "_pending_results"}, 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (3) step();
        checkOutput({name, "_idle"}, 64'(sched_if.o_busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_next"},          64'(sched_if.o_next),          64'd0);
        checkOutput({tag, "_div_start"},     64'(sched_if.o_div_start),     64'd0);
        checkOutput({tag, "_div_ref"},       64'(sched_if.o_div_reference), 64'd0);
        checkOutput({tag, "_div_err"},       64'(sched_if.o_div_error),     64'd0);
        checkOutput({tag, "_result"},        64'(sched_if.o_result),        64'd0);
        checkOutput({tag, "_result_valid"},  64'(sched_if.o_result_valid),  64'd0);
        checkOutput({tag, "_sample_idx"},    64'(sched_if.o_sample_idx),    64'd0);
        checkOutput({tag, "_zero_ref"},      64'(sched_if.o_zero_ref),      64'd0);
        checkOutput({tag, "_timeout"},       64'(sched_if.o_timeout),       64'd0);
        checkOutput({tag, "_frame_done"},    64'(sched_if.o_frame_done),    64'd0);
        checkOutput({tag, "_timeout_count"}, 64'(sched_if.o_timeout_count), 64'd0);
        checkOutput({tag, "_busy"},          64'(sched_if.o_busy),          64'd0);
    endtask

    initial begin
        int starts_before;
        int target;
        int n;
        int valid_before;

        // Quotient = (err << 16) / ref; gap = cycles since previous result.
        // Nominal frame, L=5: period 9.
        vecs[0]  = '{16'd10, 16'd5, 5, 32'h0000_8000, 1'b0, 1'b0, 0};
        vecs[1]  = '{16'd20, 16'd5, 5, 32'h0000_4000, 1'b0, 1'b0, 9};
        vecs[2]  = '{16'd30, 16'd5, 5, 32'h0000_2AAA, 1'b0, 1'b0, 9};
        vecs[3]  = '{16'd40, 16'd5, 5, 32'h0000_2000, 1'b0, 1'b0, 9};
        // Zero reference at idx 2, L=3: periods 7, 3, 7.
        vecs[4]  = '{16'd10, 16'd5, 3, 32'h0000_8000, 1'b0, 1'b0, 0};
        vecs[5]  = '{16'd20, 16'd5, 3, 32'h0000_4000, 1'b0, 1'b0, 7};
        vecs[6]  = '{16'd0,  16'd5, 3, 32'hFFFF_FFFF, 1'b1, 1'b0, 3};
        vecs[7]  = '{16'd40, 16'd5, 3, 32'h0000_2000, 1'b0, 1'b0, 7};
        // Timeouts: L=9 is one past TIMEOUT (late valid), L=8 ties, 0 hangs.
        vecs[8]  = '{16'd10, 16'd5, 2, 32'h0000_8000, 1'b0, 1'b0, 0};
        vecs[9]  = '{16'd20, 16'd6, 9, 32'h0000_0000, 1'b0, 1'b1, 12};
        vecs[10] = '{16'd30, 16'd5, 8, 32'h0000_2AAA, 1'b0, 1'b0, 12};
        vecs[11] = '{16'd40, 16'd5, 0, 32'h0000_0000, 1'b0, 1'b1, 12};
        // Two back-to-back frames, L=1: period 5 including the boundary.
        vecs[12] = '{16'd10, 16'd5, 1, 32'h0000_8000, 1'b0, 1'b0, 0};
        vecs[13] = '{16'd20, 16'd5, 1, 32'h0000_4000, 1'b0, 1'b0, 5};
        vecs[14] = '{16'd30, 16'd5, 1, 32'h0000_2AAA, 1'b0, 1'b0, 5};
        vecs[15] = '{16'd40, 16'd5, 1, 32'h0000_2000, 1'b0, 1'b0, 5};
        vecs[16] = '{16'd20, 16'd6, 1, 32'h0000_4CCC, 1'b0, 1'b0, 5};
        vecs[17] = '{16'd10, 16'd5, 1, 32'h0000_8000, 1'b0, 1'b0, 5};
        vecs[18] = '{16'd40, 16'd5, 1, 32'h0000_2000, 1'b0, 1'b0, 5};
        vecs[19] = '{16'd30, 16'd5, 1, 32'h0000_2AAA, 1'b0, 1'b0, 5};

        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_ref[i] = '0;
            mem_err[i] = '0;
            mem_lat[i] = 0;
        end

        sched_if.i_enable = 1'b0;
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
        check_all_zero("reset");

        $display("[TB] nominal frame");
        starts_before = start_count;
        applyStimulus(0, 4);
        pulse_enable();
        drain("nominal", 200);
        checkOutput("nominal_starts", 64'(start_count - starts_before), 64'd4);

        $display("[TB] zero reference frame");
        starts_before = start_count;
        applyStimulus(4, 4);
        pulse_enable();
        drain("zero_ref", 200);
        checkOutput("zero_ref_starts", 64'(start_count - starts_before), 64'd3);
        checkOutput("zero_ref_no_timeouts", 64'(sched_if.o_timeout_count), 64'd0);

        $display("[TB] timeout and tie frame");
        starts_before = start_count;
        applyStimulus(8, 4);
        pulse_enable();
        drain("timeout", 300);
        checkOutput("timeout_starts", 64'(start_count - starts_before), 64'd4);
        checkOutput("timeout_count", 64'(sched_if.o_timeout_count), 64'd2);

        $display("[TB] continuous enable then mid-frame drop");
        applyStimulus(12, 8);
        target = popped + 6;
        sched_if.i_enable = 1'b1;
        n = 0;
        while (popped < target && n < 400) begin
            step();
            n++;
        end
        checkOutput("enable_reached_idx1", 64'(popped), 64'(target));
        sched_if.i_enable = 1'b0;
        drain("enable", 200);
        checkOutput("enable_timeout_count", 64'(sched_if.o_timeout_count), 64'd2);

        $display("[TB] reset during WAIT");
        mem_ref[wr_ptr] = 16'd50;
        mem_err[wr_ptr] = 16'd5;
        mem_lat[wr_ptr] = 6;
        wr_ptr++;
        pulse_enable();
        n = 0;
        while (!sched_if.o_div_start && n < 10) begin
            step();
            n++;
        end
        checkOutput("reset_test_start_seen", 64'(sched_if.o_div_start), 64'd1);
        step();
        step();
        checkOutput("reset_test_busy_in_wait", 64'(sched_if.o_busy), 64'd1);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check_all_zero("mid_reset");
        valid_before = valid_seen;
        repeat (12) step();
        checkOutput("late_valid_ignored", 64'(valid_seen - valid_before), 64'd0);
        checkOutput("post_reset_idle", 64'(sched_if.o_busy), 64'd0);
        checkOutput("post_reset_timeout_count", 64'(sched_if.o_timeout_count), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/monopulse_scheduler.md
Name: monopulse_scheduler

Overview:
Frame-level sequencer for the monopulse divider path. It fetches reference/error sample pairs from the memory reader and launches one divider operation per pair. It guards against zero-reference divides and hung divides, and presents each quotient with an index and frame markers. It sits between memory_reader and monopulse, replacing the free-running start/valid loop in top.

Parameters:
DATA_SIZE, 64, width of reference and error samples; the result is 2*DATA_SIZE.
FRAME_LEN, 16, samples per frame (>=2).
TIMEOUT, 255, cycles to wait in WAIT for divider valid before aborting (>=1).
IDX_W, 8, width of the sample index (2**IDX_W >= FRAME_LEN).

Ports:
i_clock  in  1  single clock domain for the block.
i_reset  in  1  synchronous, active-high reset.
i_enable  in  1  run frames while high; sampled at frame boundaries and in IDLE.
i_reference  in  DATA_SIZE  current reference sample from the reader.
i_error  in  DATA_SIZE  current error sample from the reader.
o_next  out  1  one-cycle pulse that advances the reader.
o_div_start  out  1  one-cycle start pulse to the divider.
o_div_reference  out  DATA_SIZE  registered reference operand.
o_div_error  out  DATA_SIZE  registered error operand.
i_div_result  in  2*DATA_SIZE  divider quotient.
i_div_valid  in  1  divider result valid.
o_result  out  2*DATA_SIZE  registered result per sample.
o_result_valid  out  1  one-cycle pulse; o_result, o_sample_idx and the flags are valid.
o_sample_idx  out  IDX_W  index of the sample within its frame.
o_zero_ref  out  1  qualifies o_result_valid: the sample had reference==0.
o_timeout  out  1  qualifies o_result_valid: the divide timed out.
o_frame_done  out  1  one-cycle pulse, coincident with the result for sample FRAME_LEN-1.
o_timeout_count  out  8  saturating count of timeouts since reset.
o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (sync, i_reset=1): state=IDLE, idx=0, timer=0. All outputs 0, including operands, result and o_timeout_count. A reset mid-operation abandons the current divide; a divider valid arriving later is ignored in IDLE.
- IDLE: if i_enable=1, go to LOAD with idx=0.
- LOAD: register i_reference into o_div_reference and i_error into o_div_error.
  - If i_reference==0: result=all-ones, zero_ref=1, go to NEXT. The divider is not started.
  - Otherwise go to START.
- START: o_div_start=1 for exactly this cycle, timer=0, go to WAIT.
- WAIT: o_div_start=0.
  - If i_div_valid=1: capture i_div_result, go to NEXT.
  - Else timer++. When timer reaches TIMEOUT: result=0, timeout=1, o_timeout_count+1 (saturates at 255), go to NEXT.
  - If valid and timeout coincide, valid wins and no timeout is flagged.
- NEXT: drive o_result_valid=1 and o_next=1 for one cycle, with o_result, o_sample_idx=idx, o_zero_ref and o_timeout.
  - If idx==FRAME_LEN-1: also o_frame_done=1, then idx=0.
  - Otherwise idx++.
  - Go to SETTLE.
- SETTLE: one cycle for the reader's registered output to update after o_next.
  - Mid-frame: go to LOAD.
  - At a frame boundary: go to LOAD if i_enable=1, else IDLE.
- Enable semantics: deasserting i_enable mid-frame does not stop the frame. The frame always completes all FRAME_LEN samples.
- i_div_valid outside WAIT is ignored. The flags are cleared on every LOAD.
- Latency: with the divider asserting valid L cycles after the start cycle, the per-sample period is L+4 cycles (LOAD, START, WAIT×L, NEXT, SETTLE). o_result_valid rises L+2 cycles after LOAD.
- Zero-reference sample: 3 cycles per sample (LOAD, NEXT, SETTLE).
- Result and operand registers hold their values between pulses.

Test Plan:
- Nominal: FRAME_LEN=4, divider model with L=5, references 10,20,30,40 and errors 5,5,5,5 -> 4 o_result_valid pulses, idx 0..3, one start per sample, 9-cycle spacing, o_frame_done only with idx=3, then IDLE because i_enable=0.
- Zero reference: the sample at idx=2 has reference 0 -> no o_div_start for it, o_result=all-ones, o_zero_ref=1, 3-cycle sample period; the neighbouring samples are unflagged.
- Timeout: TIMEOUT=8 and the divider never responds on sample 1 -> o_timeout=1 and o_result=0 eight cycles after START, o_timeout_count=1; a late i_div_valid afterwards is ignored, and the next sample proceeds normally.
- Tie: i_div_valid on the same cycle the timer reaches TIMEOUT -> the divider result is used, o_timeout=0, and the count is unchanged.
- Enable: i_enable drops at idx=1 -> the frame completes through idx=3 and the block returns to IDLE. With i_enable held high, the next frame starts at idx=0 with no gap beyond SETTLE.
- Reset mid-WAIT: assert i_reset for 1 cycle -> all outputs 0 and IDLE the next cycle; a divider valid arriving later produces no o_result_valid; o_timeout_count=0.
